mc_control_unit: RTL and testbench
==================================

// Module: mc_control_unit
// PURPOSE
//  Multi-cycle sequencer for the RV32I datapath (R/I/L/S/B types). Decodes instrCode and steps an FSM.
//  Per state, drives the PC enable, register-file write, ALU/mux selects and a req/ready data-bus handshake.
//  Sits beside the datapath; all datapath control ports come from this block. Bus stalls are bounded by a timeout.
// PARAMETERS
//  BUS_TIMEOUT  16  max cycles busReq may wait for busReady before abort (>=2)
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  reset          in   1   synchronous, active-high
//  instrCode      in   32  current instruction (combinational from instr memory at PC)
//  busReady       in   1   data-bus completion for the current busReq
//  pcEn           out  1   PC register enable (advance to next PC)
//  regFileWe      out  1   register-file write enable
//  aluControl     out  4   ALU op: {bit30-flag,func3}
//  aluSrcMuxSel   out  1   0=RD2, 1=immExt
//  RFWDSrcMuxSel  out  1   0=aluResult, 1=busRData
//  branch         out  1   qualifies btaken for PC mux
//  busReq         out  1   data-bus request
//  busWe          out  1   1=store, 0=load (valid while busReq)
//  illegalInstr   out  1   1-cycle pulse on unsupported opcode
//  busErr         out  1   1-cycle pulse on bus timeout
// BEHAVIOUR
//  Reset: state=FETCH, timeout cnt=0, all 1-bit outputs 0.
//  Reset is sampled before any transition; asserting it mid-bus-wait drops busReq the next cycle.
//  Opcodes: R=0110011 I=0010011 L=0000011 S=0100011 B=1100011; others are illegal.
//  aluControl: R -> {instr[30],func3}. I -> {func3==101 ? instr[30] : 0, func3}. B -> {0,func3}. L/S/other -> 4'b0000 (ADD).
//  States / transitions (outputs Moore, listed = 1, all else 0):
//   FETCH  -> DECODE                                   (none)
//   DECODE -> R_EXE|I_EXE|B_EXE|L_EXE|S_EXE by opcode; illegal -> FETCH w/ pcEn, illegalInstr
//   R_EXE  -> FETCH    regFileWe, pcEn
//   I_EXE  -> FETCH    regFileWe, pcEn, aluSrcMuxSel
//   B_EXE  -> FETCH    branch, pcEn
//   L_EXE  -> L_MEM    aluSrcMuxSel
//   L_MEM  busReq, aluSrcMuxSel; busReady -> L_WB; else stay
//   L_WB   -> FETCH    regFileWe, RFWDSrcMuxSel, aluSrcMuxSel, pcEn
//   S_EXE  -> S_MEM    aluSrcMuxSel
//   S_MEM  busReq, busWe, aluSrcMuxSel; busReady -> FETCH with pcEn same cycle; else stay
//  Latency (FETCH to next FETCH): R/I/B=3, S=4+w, L=5+w; w=cycles busReady low in *_MEM.
//  Timeout: cnt clears on entering *_MEM and increments each cycle in *_MEM with busReady=0.
//   On the cycle cnt==BUS_TIMEOUT-1 with busReady=0: busErr=1, pcEn=1, next=FETCH, no regFileWe.
//   The abandoned load is skipped.
//  busReady outside *_MEM is ignored. busReady and timeout in the same cycle: busReady wins.
//  busReq/busWe are stable from *_MEM entry until completion or abort; never asserted in other states.
//  At most one of regFileWe/busWe per instruction; pcEn is exactly one cycle per instruction.
// TESTING
//  1. add x3,x1,x2 (0x002081B3) after reset -> FETCH,DECODE,R_EXE; cycle3: regFileWe=1, pcEn=1, aluControl=0000.
//  2. sub (0x402081B3) -> aluControl=1000.
//     srai x3,x1,2 (0x4020D193) -> aluControl=1101, aluSrcMuxSel=1.
//     beq x1,x2 (0x00208463) -> branch=1, pcEn=1, regFileWe=0.
//  3. lw x5,4(x1) (0x0040A283), busReady low 3 cycles -> busReq high 4 cycles.
//     Then L_WB: regFileWe=1, RFWDSrcMuxSel=1, pcEn=1; total 8 cycles.
//  4. sw x2,8(x1) (0x0020A423), busReady=1 on first S_MEM cycle -> busReq=busWe=pcEn=1 that cycle; 4 cycles total.
//  5. lw with busReady held 0, BUS_TIMEOUT=16 -> busReq high 16 cycles, busErr and pcEn pulse on 16th, regFileWe never 1.
//  6. Opcode 0x0000007F -> illegalInstr=1, pcEn=1 in DECODE.
//     Then reset asserted mid L_MEM -> next cycle all outputs 0, state FETCH.

Source files
------------

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_unit
// Purpose  : Multi-cycle RV32I (R/I/L/S/B) sequencer driving datapath control
//            and a req/ready data-bus handshake with a bounded wait.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_unit #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
    input  logic        busReady,
    output logic        pcEn,
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcMuxSel,
    output logic        RFWDSrcMuxSel,
    output logic        branch,
    output logic        busReq,
    output logic        busWe,
    output logic        illegalInstr,
    output logic        busErr
);

    localparam int         CNT_W   = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [6:0] c_OP_R  = 7'b0110011;
    localparam logic [6:0] c_OP_I  = 7'b0010011;
    localparam logic [6:0] c_OP_L  = 7'b0000011;
    localparam logic [6:0] c_OP_S  = 7'b0100011;
    localparam logic [6:0] c_OP_B  = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_R_EXE  = 4'd2,
        S_I_EXE  = 4'd3,
        S_B_EXE  = 4'd4,
        S_L_EXE  = 4'd5,
        S_L_MEM  = 4'd6,
        S_L_WB   = 4'd7,
        S_S_EXE  = 4'd8,
        S_S_MEM  = 4'd9
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [6:0]         w_opcode;
    logic [2:0]         w_func3;
    logic               w_bit30;
    logic               w_timeout;
    logic               w_unused_instr_bits;

    assign w_opcode            = instrCode[6:0];
    assign w_func3             = instrCode[14:12];
    assign w_bit30             = instrCode[30];
    assign w_unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};
    assign w_timeout           = (cnt_q == CNT_W'(BUS_TIMEOUT - 1));

    always_comb begin
        aluControl = 4'b0000;
        case (w_opcode)
            c_OP_R:  aluControl = {w_bit30, w_func3};
            c_OP_I:  aluControl = {(w_func3 == 3'b101) ? w_bit30 : 1'b0, w_func3};
            c_OP_B:  aluControl = {1'b0, w_func3};
            default: aluControl = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pcEn          = 1'b0;
        regFileWe     = 1'b0;
        aluSrcMuxSel  = 1'b0;
        RFWDSrcMuxSel = 1'b0;
        branch        = 1'b0;
        busReq        = 1'b0;
        busWe         = 1'b0;
        illegalInstr  = 1'b0;
        busErr        = 1'b0;

        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    c_OP_R: state_d = S_R_EXE;
                    c_OP_I: state_d = S_I_EXE;
                    c_OP_B: state_d = S_B_EXE;
                    c_OP_L: state_d = S_L_EXE;
                    c_OP_S: state_d = S_S_EXE;
                    default: begin
                        pcEn         = 1'b1;
                        illegalInstr = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_R_EXE: begin
                regFileWe = 1'b1;
                pcEn      = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXE: begin
                regFileWe    = 1'b1;
                pcEn         = 1'b1;
                aluSrcMuxSel = 1'b1;
                state_d      = S_FETCH;
            end
            S_B_EXE: begin
                branch  = 1'b1;
                pcEn    = 1'b1;
                state_d = S_FETCH;
            end
            S_L_EXE: begin
                aluSrcMuxSel = 1'b1;
                cnt_d        = '0;
                state_d      = S_L_MEM;
            end
            S_L_MEM: begin
                busReq       = 1'b1;
                aluSrcMuxSel = 1'b1;
                if (busReady) begin
                    state_d = S_L_WB;
                end else if (w_timeout) begin
                    // abandoned load: skip write-back, move on to the next instruction
                    busErr  = 1'b1;
                    pcEn    = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_L_WB: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 1'b1;
                aluSrcMuxSel  = 1'b1;
                pcEn          = 1'b1;
                state_d       = S_FETCH;
            end
            S_S_EXE: begin
                aluSrcMuxSel = 1'b1;
                cnt_d        = '0;
                state_d      = S_S_MEM;
            end
            S_S_MEM: begin
                busReq       = 1'b1;
                busWe        = 1'b1;
                aluSrcMuxSel = 1'b1;
                if (busReady) begin
                    pcEn    = 1'b1;
                    state_d = S_FETCH;
                end else if (w_timeout) begin
                    busErr  = 1'b1;
                    pcEn    = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_unit
// Purpose  : Scoreboard bench: per-cycle expected control vectors are queued
//            per instruction and compared against the sequencer outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_unit;

    localparam int TO = 16;

    localparam logic [31:0] c_ADD  = 32'h002081B3;
    localparam logic [31:0] c_SUB  = 32'h402081B3;
    localparam logic [31:0] c_SRAI = 32'h4020D193;
    localparam logic [31:0] c_ADDI = 32'h00108093;
    localparam logic [31:0] c_XOR  = 32'h0020C1B3;
    localparam logic [31:0] c_BEQ  = 32'h00208463;
    localparam logic [31:0] c_BNE  = 32'h00209463;
    localparam logic [31:0] c_LW   = 32'h0040A283;
    localparam logic [31:0] c_SW   = 32'h0020A423;
    localparam logic [31:0] c_ILL  = 32'h0000007F;

    logic        clk;
    logic        reset;
    logic [31:0] instrCode;
    logic        busReady;
    logic        pcEn, regFileWe, aluSrcMuxSel, RFWDSrcMuxSel, branch;
    logic        busReq, busWe, illegalInstr, busErr;
    logic [3:0]  aluControl;
    logic [12:0] obs;

    int n_checks;
    int n_fails;

    logic [12:0] exp_q[$];
    logic        rdy_q[$];

    mc_control_unit #(.BUS_TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .instrCode     (instrCode),
        .busReady      (busReady),
        .pcEn          (pcEn),
        .regFileWe     (regFileWe),
        .aluControl    (aluControl),
        .aluSrcMuxSel  (aluSrcMuxSel),
        .RFWDSrcMuxSel (RFWDSrcMuxSel),
        .branch        (branch),
        .busReq        (busReq),
        .busWe         (busWe),
        .illegalInstr  (illegalInstr),
        .busErr        (busErr)
    );

    assign obs = {pcEn, regFileWe, aluSrcMuxSel, RFWDSrcMuxSel, branch,
                  busReq, busWe, illegalInstr, busErr, aluControl};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // vector order: pcEn regFileWe aluSrc RFWDSrc branch busReq busWe illegal busErr aluControl
    function automatic logic [12:0] mk(input logic [3:0] alu, input logic pc, we, src, wd, br,
                                       req, bwe, ill, err);
        return {pc, we, src, wd, br, req, bwe, ill, err, alu};
    endfunction

    function automatic logic [3:0] alu_model(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011: return {ins[30], ins[14:12]};
            7'b0010011: return {(ins[14:12] == 3'b101) ? ins[30] : 1'b0, ins[14:12]};
            7'b1100011: return {1'b0, ins[14:12]};
            default:    return 4'b0000;
        endcase
    endfunction

    task automatic push(input logic [12:0] e, input logic r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // w = cycles busReady stays low in *_MEM; w >= TO means never ready
    task automatic build(input logic [31:0] ins, input int w);
        logic [3:0] a;
        logic       is_store;
        a = alu_model(ins);
        push(mk(a,0,0,0,0,0,0,0,0,0), rnd_bit());
        case (ins[6:0])
            7'b0110011: begin
                push(mk(a,0,0,0,0,0,0,0,0,0), rnd_bit());
                push(mk(a,1,1,0,0,0,0,0,0,0), rnd_bit());
            end
            7'b0010011: begin
                push(mk(a,0,0,0,0,0,0,0,0,0), rnd_bit());
                push(mk(a,1,1,1,0,0,0,0,0,0), rnd_bit());
            end
            7'b1100011: begin
                push(mk(a,0,0,0,0,0,0,0,0,0), rnd_bit());
                push(mk(a,1,0,0,0,1,0,0,0,0), rnd_bit());
            end
            7'b0000011, 7'b0100011: begin
                is_store = (ins[6:0] == 7'b0100011);
                push(mk(a,0,0,0,0,0,0,0,0,0), rnd_bit());
                push(mk(a,0,0,1,0,0,0,0,0,0), rnd_bit());
                for (int k = 0; k < TO; k++) begin
                    if (k >= w) begin
                        push(mk(a,is_store,0,1,0,0,1,is_store,0,0), 1'b1);
                        if (!is_store)
                            push(mk(a,1,1,1,1,0,0,0,0,0), rnd_bit());
                        break;
                    end else if (k == TO - 1) begin
                        push(mk(a,1,0,1,0,0,1,is_store,0,1), 1'b0);
                    end else begin
                        push(mk(a,0,0,1,0,0,1,is_store,0,0), 1'b0);
                    end
                end
            end
            default: push(mk(a,1,0,0,0,0,0,0,1,0), rnd_bit());
        endcase
    endtask

    // entered at posedge+1 with the DUT in FETCH
    task automatic run(input string tag, input logic [31:0] ins, input int w);
        int cyc;
        instrCode = ins;
        build(ins, w);
        cyc = 0;
        while (exp_q.size() > 0) begin
            busReady = rdy_q.pop_front();
            @(negedge clk);
            check_eq($sformatf("%s c%0d", tag, cyc), 32'(obs), 32'(exp_q.pop_front()));
            @(posedge clk);
            #1;
            cyc++;
        end
        busReady = 1'b0;
    endtask

    initial begin
        logic [31:0] pool [10];
        n_checks  = 0;
        n_fails   = 0;
        reset     = 1'b1;
        instrCode = 32'h0;
        busReady  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outs", 32'(obs), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run("add",  c_ADD,  0);
        run("sub",  c_SUB,  0);
        run("srai", c_SRAI, 0);
        run("addi", c_ADDI, 0);
        run("xor",  c_XOR,  0);
        run("beq",  c_BEQ,  0);
        run("bne",  c_BNE,  0);
        run("lw_w3", c_LW,  3);
        run("lw_w0", c_LW,  0);
        run("sw_w0", c_SW,  0);
        run("sw_w2", c_SW,  2);
        run("lw_to", c_LW,  TO + 4);
        run("sw_to", c_SW,  TO + 4);
        run("lw_edge", c_LW, TO - 1);
        run("sw_edge", c_SW, TO - 1);
        run("illegal", c_ILL, 0);

        pool = '{c_ADD, c_SUB, c_SRAI, c_ADDI, c_XOR, c_BEQ, c_BNE, c_LW, c_SW, c_ILL};
        for (int i = 0; i < 12; i++)
            run($sformatf("rnd%0d", i), pool[$urandom_range(0, 9)], int'($urandom_range(0, 5)));

        // reset while waiting in L_MEM
        instrCode = c_LW;
        busReady  = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("mid_lmem", 32'(obs), 32'(mk(4'b0000,0,0,1,0,0,1,0,0,0)));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_mid_lmem", 32'(obs), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run("post_rst_add", c_ADD, 0);
        run("post_rst_lw", c_LW, TO - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
